// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Holds parity-mode constants, the transmit state encoding and the
// clocks-per-bit helper used by the top and the baud generator.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clocks per line bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..DIV-1 and flags the last clock of each bit.
// Ports: CLK, Rstn (async active-low), clear (restart count at 0),
//        bit_tick (last clock of a bit), pre_tick (clock before bit_tick).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic CLK,
    input  logic Rstn,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    // Guard keeps the width legal even when DIV is rejected by the top.
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == CW'(DIV - 1))) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == CW'(DIV - 1));
    // Lets the top register a pulse that lands on a bit's final clock.
    assign pre_tick = (cnt_q == CW'(DIV - 2));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, optional parity, 1/2 stop bits.
// Ports: CLK, Rstn, TX_Data/TX_Valid/TX_Ready handshake in; TX_Busy, TX_Done_Sig,
//        TX_Pin_Out (idle high). All outputs registered; start bit one clock after accept.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 Rstn,
    input  logic [DATA_BITS-1:0] TX_Data,
    input  logic                 TX_Valid,
    output logic                 TX_Ready,
    output logic                 TX_Busy,
    output logic                 TX_Done_Sig,
    output logic                 TX_Pin_Out
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int IW  = $clog2(DATA_BITS);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: clocks per bit must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_width
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_q, par_d;
    logic                 pin_q, pin_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic accept;
    logic bit_tick;
    logic pre_tick;
    logic last_stop;

    assign accept    = ready_q && TX_Valid;
    assign last_stop = (STOP_BITS == 1) || stop_idx_q;

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud (
        .CLK      (CLK),
        .Rstn     (Rstn),
        .clear    (accept),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        pin_d      = pin_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    shift_d = TX_Data;
                    // Parity is fixed at accept from the latched payload.
                    par_d   = (^TX_Data) ^ (PARITY == PAR_ODD);
                    pin_d   = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    pin_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            pin_d   = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            pin_d      = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        pin_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d    = ST_STOP;
                    pin_d      = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                // Registered done must already be high on the final clock.
                if (pre_tick && last_stop) begin
                    done_d = 1'b1;
                end
                if (bit_tick) begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pin_d   = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            pin_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            pin_q      <= pin_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TX_Pin_Out  = pin_q;
    assign TX_Ready    = ready_q;
    assign TX_Busy     = busy_q;
    assign TX_Done_Sig = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg with four configurations (8N1, 8E1, 8O1, 7N2), DIV=10.
// Table-driven frames plus hand sequences for back-to-back, busy-ignore and reset.
// Cycle c=0 is the sample just after the accept edge (start bit already low).
module tb_uart_tx_cfg;

    logic       CLK = 1'b0;
    logic       Rstn = 1'b0;
    logic [3:0] vld;
    logic [8:0] dat [4];
    logic [3:0] rdy, bsy, dn, pin;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .CLK(CLK), .Rstn(Rstn), .TX_Data(dat[0][7:0]), .TX_Valid(vld[0]), .TX_Ready(rdy[0]),
        .TX_Busy(bsy[0]), .TX_Done_Sig(dn[0]), .TX_Pin_Out(pin[0]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .CLK(CLK), .Rstn(Rstn), .TX_Data(dat[1][7:0]), .TX_Valid(vld[1]), .TX_Ready(rdy[1]),
        .TX_Busy(bsy[1]), .TX_Done_Sig(dn[1]), .TX_Pin_Out(pin[1]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .CLK(CLK), .Rstn(Rstn), .TX_Data(dat[2][7:0]), .TX_Valid(vld[2]), .TX_Ready(rdy[2]),
        .TX_Busy(bsy[2]), .TX_Done_Sig(dn[2]), .TX_Pin_Out(pin[2]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .CLK(CLK), .Rstn(Rstn), .TX_Data(dat[3][6:0]), .TX_Valid(vld[3]), .TX_Ready(rdy[3]),
        .TX_Busy(bsy[3]), .TX_Done_Sig(dn[3]), .TX_Pin_Out(pin[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // frame: line bits LSB = start bit, one entry per bit period, hand-derived.
    typedef struct {
        int          inst;
        logic [8:0]  d;
        logic [11:0] frame;
        int          nbits;
        int          len;
    } vec_t;

    vec_t vt [9];

    task automatic send(input int inst, input logic [8:0] d, input logic [11:0] frame,
                        input int nbits, input int len, input bit disturb, input string tag);
        int          done_cyc;
        int          done_cnt;
        int          bad;
        logic [11:0] got;
        done_cyc = -1;
        done_cnt = 0;
        bad      = 0;
        got      = '0;
        @(negedge CLK);
        dat[inst] = d;
        vld[inst] = 1'b1;
        chk({tag, " ready_before"}, 32'(rdy[inst]), 32'd1);
        @(posedge CLK);
        #1;
        vld[inst] = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(bsy[inst]), 32'd1);
        chk({tag, " ready_after_accept"}, 32'(rdy[inst]), 32'd0);
        for (int c = 0; c <= len + 2; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
            end
            if ((c % 10 == 5) && (c / 10 < nbits)) got[c/10] = pin[inst];
            if (dn[inst]) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
            end
            if (c == len) begin
                chk({tag, " ready_at_end"}, 32'(rdy[inst]), 32'd1);
                chk({tag, " busy_at_end"}, 32'(bsy[inst]), 32'd0);
            end
            if (disturb && c == 30) begin
                dat[inst] = ~d;
                vld[inst] = 1'b1;
            end
            if (disturb && c == 31) vld[inst] = 1'b0;
        end
        chk({tag, " frame_bits"}, 32'(got), 32'(frame));
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(len - 1));
        chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
        if (disturb) begin
            for (int c = 0; c < 20; c++) begin
                @(posedge CLK);
                #1;
                if (bsy[inst] || !pin[inst] || dn[inst]) bad++;
            end
            chk({tag, " no_extra_frame"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          d1, d2, bad;
        logic [7:0]  b1, b2;

        vld = '0;
        for (int i = 0; i < 4; i++) dat[i] = '0;

        vt[0] = '{0, 9'h055, 12'h2AA, 10, 100};
        vt[1] = '{1, 9'h055, 12'h4AA, 11, 110};
        vt[2] = '{2, 9'h055, 12'h6AA, 11, 110};
        vt[3] = '{1, 9'h007, 12'h60E, 11, 110};
        vt[4] = '{2, 9'h007, 12'h40E, 11, 110};
        vt[5] = '{3, 9'h07F, 12'h3FE, 10, 100};
        vt[6] = '{3, 9'h0AA, 12'h354, 10, 100};
        vt[7] = '{0, 9'h000, 12'h200, 10, 100};
        vt[8] = '{0, 9'h0FF, 12'h3FE, 10, 100};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst%0d pin", i), 32'(pin[i]), 32'd1);
            chk($sformatf("rst%0d ready", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst%0d busy", i), 32'(bsy[i]), 32'd0);
            chk($sformatf("rst%0d done", i), 32'(dn[i]), 32'd0);
        end
        @(negedge CLK);
        Rstn = 1'b1;

        for (int v = 0; v < 9; v++) begin
            send(vt[v].inst, vt[v].d, vt[v].frame, vt[v].nbits, vt[v].len, 1'b0,
                 $sformatf("vec%0d", v));
        end

        // Back-to-back on 8N1 with TX_Valid held high
        d1 = -1;
        d2 = -1;
        b1 = '0;
        b2 = '0;
        @(negedge CLK);
        dat[0] = 9'h0A5;
        vld[0] = 1'b1;
        @(posedge CLK);
        #1;
        dat[0] = 9'h03C;
        for (int c = 0; c <= 215; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
            end
            if (c >= 15 && c <= 85 && (c % 10 == 5)) b1[(c-15)/10] = pin[0];
            if (c >= 116 && c <= 186 && (c % 10 == 6)) b2[(c-116)/10] = pin[0];
            if (dn[0]) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 99)  chk("b2b stop_high", 32'(pin[0]), 32'd1);
            if (c == 100) begin
                chk("b2b gap_high", 32'(pin[0]), 32'd1);
                chk("b2b ready_gap", 32'(rdy[0]), 32'd1);
            end
            if (c == 101) begin
                chk("b2b second_start", 32'(pin[0]), 32'd0);
                vld[0] = 1'b0;
            end
        end
        chk("b2b byte1", 32'(b1), 32'h0A5);
        chk("b2b byte2", 32'(b2), 32'h03C);
        chk("b2b done1_cycle", 32'(d1), 32'd99);
        chk("b2b done_spacing", 32'(d2 - d1), 32'd101);
        repeat (20) @(posedge CLK);

        // Busy ignore: data change and valid pulse mid-frame
        send(0, 9'h05A, 12'h2B4, 10, 100, 1'b1, "busy_ign");

        // Reset mid-frame at cycle 35 (data bit 2 of 0xC3 is 0)
        @(negedge CLK);
        dat[0] = 9'h0C3;
        vld[0] = 1'b1;
        @(posedge CLK);
        #1;
        vld[0] = 1'b0;
        repeat (35) @(posedge CLK);
        #2;
        chk("rstmid pin_low_before", 32'(pin[0]), 32'd0);
        Rstn = 1'b0;
        #1;
        chk("rstmid pin_async_high", 32'(pin[0]), 32'd1);
        chk("rstmid ready", 32'(rdy[0]), 32'd1);
        chk("rstmid busy", 32'(bsy[0]), 32'd0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            if (dn[0] || !pin[0]) bad++;
        end
        @(negedge CLK);
        Rstn = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge CLK);
            #1;
            if (dn[0] || !pin[0] || bsy[0]) bad++;
        end
        chk("rstmid quiet_after", 32'(bad), 32'd0);
        send(0, 9'h081, 12'h302, 10, 100, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter: a single block that replaces the fixed 8N1 data-control / bps / tx-control trio.
- Configurable data width, parity mode and stop-bit count.
- Internal baud generator derived from the clock frequency.
- Valid/ready input handshake so any upstream producer (FIFO, command sequencer) can feed it frames back-to-back.
- Drives the board TX pin directly.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit. DIV must be at least 2, checked at elaboration.
- DATA_BITS, 8: payload bits per frame. Legal range is 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Value 3 is an elaboration error.
- STOP_BITS, 1: 1 or 2.

Ports:
- CLK  in  1  system clock.
- Rstn  in  1  asynchronous active-low reset.
- TX_Data  in  DATA_BITS  frame payload, sampled only on an accept cycle.
- TX_Valid  in  1  producer has a frame.
- TX_Ready  out  1  block can accept a frame this cycle.
- TX_Busy  out  1  a frame is on the line.
- TX_Done_Sig  out  1  one-cycle pulse at the end of the final stop bit.
- TX_Pin_Out  out  1  serial line, idle high.

Behaviour:
- Clock and reset: one clock, CLK. Reset Rstn is asynchronous, active-low.
- Reset values: TX_Pin_Out=1, TX_Ready=1, TX_Busy=0, TX_Done_Sig=0. State=IDLE, baud counter=0, shift register=0.
- Reset mid-frame: the line returns high immediately (asynchronously) and the frame is discarded. No Done pulse is produced.
- Accept: in IDLE, TX_Valid && TX_Ready on a rising edge latches TX_Data. TX_Data and TX_Valid are ignored in every other cycle.
- After accept: TX_Ready and TX_Busy change in the next cycle (Ready falls, Busy rises).
- Latency: TX_Pin_Out goes low (start bit) on the clock after accept. All outputs are registered.
- Bit timing: the baud counter restarts at accept and counts 0..DIV-1. Each line bit lasts exactly DIV clocks. No cumulative drift is permitted.
- State machine:
  - IDLE -> START on accept.
  - START -> DATA after DIV clocks.
  - DATA sends DATA_BITS bits LSB first, with a bit index 0..DATA_BITS-1. After the last bit it goes to PARITY if PARITY != 0, otherwise to STOP.
  - PARITY -> STOP after DIV clocks.
  - STOP lasts STOP_BITS*DIV clocks with the line high, then returns to IDLE.
- Parity bit: XOR-reduce of the latched payload. Even mode sends that value; odd mode sends its inverse.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks, measured from the start-bit falling edge.
- TX_Done_Sig: high for exactly one clock, on the last clock of the last stop bit. That same edge moves the state to IDLE, so TX_Ready=1 in the following cycle.
- Back-to-back frames: if TX_Valid is held high, the next accept happens in the first IDLE cycle. The next start bit therefore begins 1 clock after the previous stop bit ends, giving a guaranteed minimum 1-clock inter-frame high.
- Unused upper payload bits do not exist: the width is exactly DATA_BITS.
- TX_Valid dropping without an accept has no effect. The block never drops or truncates an accepted frame.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the state encoding IDLE/START/DATA/PARITY/STOP;
  - a constant function calc_div(clk_freq, baud) used by both modules.
- Sub-module uart_baud_gen has inputs CLK, Rstn and clear, and output bit_tick. It produces a one-clock pulse every DIV clocks, restarted by clear (driven on accept).
- The FSM, shift register and parity logic stay in uart_tx_cfg.

Test Plan:
- Run all scenarios with CLK_FREQ=1000, BAUD=100, giving DIV=10.
1. Basic 8N1: 8N1, send 0x55 -> line low 10 clk, then 1,0,1,0,1,0,1,0 (10 clk each), then high 10 clk. Done pulses at clk 100 after the start edge. Ready is back at 101.
2. 8E1 and 8O1: send 0x55 (4 ones) -> parity bit 0 even / 1 odd. Send 0x07 -> parity bit 1 even / 0 odd. Frame length is 110 clk.
3. 7N2: send 0x7F -> 7 data bits all 1, stop held high 20 clk, frame 100 clk. Bit 7 of the bench source is never transmitted.
4. Back-to-back: hold TX_Valid=1 with 0xA5 then 0x3C -> exactly 1 high clock between stop end and the second start. Two Done pulses 101 clk apart. Decoded bytes are 0xA5, 0x3C.
5. Busy ignore: change TX_Data mid-frame and pulse TX_Valid while Busy -> transmitted byte is unchanged and there is no extra frame.
6. Reset mid-frame: assert Rstn=0 at clk 35 of a frame -> TX_Pin_Out=1 with no clock edge needed. Ready=1 and no Done pulse. After release, a new 0x81 frame is transmitted correctly.
